// File: rtl/dili_montgomery_pipe.sv
// Pipelined Dilithium Montgomery reduction r = a * 2^-32 mod Q on a valid/ready stream with tag sideband.
// Define DILI_MONT_REDUCE32_EN to append a reduce32 stage (latency 4 instead of 3).
module dili_montgomery_pipe #(
   parameter int WIDTH = 32,
   parameter int QINV  = 58728449,
   parameter int Q     = 8380417,
   parameter int TAG_W = 8
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic signed [2*WIDTH-1:0]   a_i,
   input  logic        [TAG_W-1:0]     tag_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   output logic signed [WIDTH-1:0]     a_o,
   output logic        [TAG_W-1:0]     tag_o,
   output logic                        valid_o,
   input  logic                        ready_i,
   output logic                        busy_o
);

   localparam int W2 = 2 * WIDTH;
   localparam logic        [WIDTH-1:0] QINV_L = WIDTH'(QINV);
   localparam logic signed [W2-1:0]    Q_L    = W2'(Q);

   // S1: t, S2: p, S3: r; S1/S2 also carry the original product
   logic                     v1, v2, v3;
   logic signed [W2-1:0]     a1, a2;
   logic        [TAG_W-1:0]  tag1, tag2, tag3;
   logic        [WIDTH-1:0]  t1;
   logic signed [W2-1:0]     p2;
   logic signed [WIDTH-1:0]  r3;

   logic load1, load2, load3;

   logic        [WIDTH-1:0]  t_next;
   logic signed [W2-1:0]     p_next;
   logic signed [W2-1:0]     diff;
   logic signed [WIDTH-1:0]  r_next;

   assign t_next = a_i[WIDTH-1:0] * QINV_L;
   assign p_next = $signed({{WIDTH{t1[WIDTH-1]}}, t1}) * Q_L;
   assign diff   = a2 - p2;
   // Low WIDTH bits of diff are zero by construction, so the shift is exact.
   assign r_next = WIDTH'(diff >>> WIDTH);

`ifdef DILI_MONT_REDUCE32_EN
   localparam logic signed [WIDTH-1:0] HALF_L = WIDTH'(1 << 22);
   localparam logic signed [WIDTH-1:0] Q_W    = WIDTH'(Q);

   logic                     v4;
   logic        [TAG_W-1:0]  tag4;
   logic signed [WIDTH-1:0]  r4;
   logic                     load4;
   logic signed [WIDTH-1:0]  rsum, qest, r4_next;

   assign rsum    = r3 + HALF_L;
   assign qest    = rsum >>> 23;
   assign r4_next = r3 - qest * Q_W;

   assign load4   = !v4 || ready_i;
   assign load3   = !v3 || load4;
   assign a_o     = r4;
   assign tag_o   = tag4;
   assign valid_o = v4;
   assign busy_o  = v1 | v2 | v3 | v4;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v4   <= 1'b0;
         tag4 <= '0;
         r4   <= '0;
      end else if (load4) begin
         v4 <= v3;
         if (v3) begin
            tag4 <= tag3;
            r4   <= r4_next;
         end
      end
   end
`else
   assign load3   = !v3 || ready_i;
   assign a_o     = r3;
   assign tag_o   = tag3;
   assign valid_o = v3;
   assign busy_o  = v1 | v2 | v3;
`endif

   // A stage takes new data when it is empty or its contents move on this cycle.
   assign load2   = !v2 || load3;
   assign load1   = !v1 || load2;
   assign ready_o = load1;

   // NOTE: sequential state uses non-blocking assignments so every stage samples the pre-edge value of its predecessor.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1   <= 1'b0;
         v2   <= 1'b0;
         v3   <= 1'b0;
         a1   <= '0;
         a2   <= '0;
         tag1 <= '0;
         tag2 <= '0;
         tag3 <= '0;
         t1   <= '0;
         p2   <= '0;
         r3   <= '0;
      end else begin
         if (load1) begin
            v1 <= valid_i;
            if (valid_i) begin
               a1   <= a_i;
               tag1 <= tag_i;
               t1   <= t_next;
            end
         end
         if (load2) begin
            v2 <= v1;
            if (v1) begin
               a2   <= a1;
               tag2 <= tag1;
               p2   <= p_next;
            end
         end
         if (load3) begin
            v3 <= v2;
            if (v2) begin
               tag3 <= tag2;
               r3   <= r_next;
            end
         end
      end
   end

endmodule
